// File: rtl/kmat_decode_sched.sv
// Key-decode pass sequencer: K-matrix RAM fill, decode hand-off,
// key latch and valid/ack delivery.
module kmat_decode_sched #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int WORD_W  = 64,
  parameter int K_W     = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_sec_level,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  output logic              o_dec_start,
  output logic [2:0]        o_dec_sec_level,
  input  logic              i_dec_k_mat_en,
  input  logic [ADDR_W-1:0] i_dec_k_mat_addr,
  output logic [WORD_W-1:0] o_dec_k_mat,
  input  logic [K_W-1:0]    i_dec_k,
  input  logic              i_dec_done,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [WORD_W-1:0] o_ram_wdata,
  input  logic [WORD_W-1:0] i_ram_rdata,
  output logic [K_W-1:0]    o_k,
  output logic              o_k_valid,
  input  logic              i_k_ack,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DEC  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int CW   = ADDR_W + 1;
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [WD_W-1:0] r_wd;
  logic [2:0]      r_lvl;
  logic            r_dec_start;
  logic            r_err;
  logic            r_k_valid;
  logic [K_W-1:0]  r_k;

  logic w_lvl_ok;
  logic w_fill;
  logic w_dec;
  logic w_gnt;
  logic w_full;
  logic w_to;

  assign w_lvl_ok = (i_sec_level == 3'd1) ||
                    (i_sec_level == 3'd3) ||
                    (i_sec_level == 3'd5);
  assign w_fill = (r_state == S_FILL);
  assign w_dec  = (r_state == S_DEC);
  assign w_gnt  = w_fill && i_wr_req;
  assign w_full = w_gnt && (r_cnt == CW'(DEPTH - 1));
  // Done on the last watchdog cycle still wins over the timeout.
  assign w_to   = w_dec && !i_dec_done &&
                  (r_wd == WD_W'(TIMEOUT - 1));

  assign o_wr_gnt        = w_gnt;
  assign o_dec_start     = r_dec_start;
  assign o_dec_sec_level = r_lvl;
  assign o_dec_k_mat     = i_ram_rdata;
  assign o_k             = r_k;
  assign o_k_valid       = r_k_valid;
  assign o_busy          = (r_state != S_IDLE);
  assign o_err           = r_err;

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_gnt) begin
      o_ram_en    = 1'b1;
      o_ram_we    = 1'b1;
      o_ram_addr  = i_wr_addr;
      o_ram_wdata = i_wr_data;
    end else if (w_dec) begin
      o_ram_en   = i_dec_k_mat_en;
      o_ram_addr = i_dec_k_mat_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_lvl       <= 3'd1;
      r_dec_start <= 1'b0;
      r_err       <= 1'b0;
      r_k_valid   <= 1'b0;
      r_k         <= '0;
    end else begin
      r_dec_start <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_lvl_ok) begin
              r_lvl   <= i_sec_level;
              r_cnt   <= '0;
              r_state <= S_FILL;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_gnt) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_full) begin
            r_state     <= S_DEC;
            r_dec_start <= 1'b1;
            r_wd        <= '0;
          end
        end
        S_DEC: begin
          r_wd <= r_wd + 1'b1;
          if (i_dec_done) begin
            r_k       <= i_dec_k;
            r_k_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else if (w_to) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (i_k_ack) begin
            r_k_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmat_decode_sched.sv
// Directed bench for kmat_decode_sched with a behavioural
// single-port RAM (1-cycle read latency).
module tb_kmat_decode_sched;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [2:0]    i_sec_level;
  logic          i_wr_req;
  logic [3:0]    i_wr_addr;
  logic [63:0]   i_wr_data;
  logic          o_wr_gnt;
  logic          o_dec_start;
  logic [2:0]    o_dec_sec_level;
  logic          i_dec_k_mat_en;
  logic [3:0]    i_dec_k_mat_addr;
  logic [63:0]   o_dec_k_mat;
  logic [255:0]  i_dec_k;
  logic          i_dec_done;
  logic          o_ram_en;
  logic          o_ram_we;
  logic [3:0]    o_ram_addr;
  logic [63:0]   o_ram_wdata;
  logic [63:0]   i_ram_rdata;
  logic [255:0]  o_k;
  logic          o_k_valid;
  logic          i_k_ack;
  logic          o_busy;
  logic          o_err;

  logic [63:0]   mem [16];
  logic [255:0]  key_a5;
  int            n_chk = 0;
  int            n_pass = 0;
  int            grants;
  int            cyc;

  always #5 i_clk = ~i_clk;

  kmat_decode_sched dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start(i_start), .i_sec_level(i_sec_level),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_gnt(o_wr_gnt),
    .o_dec_start(o_dec_start),
    .o_dec_sec_level(o_dec_sec_level),
    .i_dec_k_mat_en(i_dec_k_mat_en),
    .i_dec_k_mat_addr(i_dec_k_mat_addr),
    .o_dec_k_mat(o_dec_k_mat),
    .i_dec_k(i_dec_k), .i_dec_done(i_dec_done),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata),
    .o_k(o_k), .o_k_valid(o_k_valid), .i_k_ack(i_k_ack),
    .o_busy(o_busy), .o_err(o_err)
  );

  always @(posedge i_clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      else          i_ram_rdata <= mem[o_ram_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] lvl);
    i_start = 1'b1;
    i_sec_level = lvl;
    tick();
    i_start = 1'b0;
  endtask

  task automatic fill(input int n, output int g);
    g = 0;
    for (int i = 0; i < n; i++) begin
      i_wr_req  = 1'b1;
      i_wr_addr = 4'(i);
      i_wr_data = 64'(i);
      #1;
      if (o_wr_gnt && o_ram_we && o_ram_addr == 4'(i)) g++;
      if (o_dec_start) g = -100;
      tick();
    end
    i_wr_req = 1'b0;
  endtask

  initial begin
    key_a5 = {32{8'hA5}};
    i_rst = 1'b1;
    i_start = 0; i_sec_level = 0;
    i_wr_req = 0; i_wr_addr = 0; i_wr_data = 0;
    i_dec_k_mat_en = 0; i_dec_k_mat_addr = 0;
    i_dec_k = 0; i_dec_done = 0; i_k_ack = 0;
    i_ram_rdata = 0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("rst_busy", 256'(o_busy), 256'(0));
    chk("rst_valid", 256'(o_k_valid), 256'(0));
    chk("rst_k", o_k, 256'(0));
    chk("rst_lvl", 256'(o_dec_sec_level), 256'(1));
    chk("rst_err_start", 256'({o_err, o_dec_start}), 256'(0));

    // Fill at level 5
    do_start(3'd5);
    chk("fill_busy", 256'(o_busy), 256'(1));
    fill(16, grants);
    chk("fill_grants", 256'(grants), 256'(16));
    chk("dec_start", 256'(o_dec_start), 256'(1));
    chk("dec_lvl", 256'(o_dec_sec_level), 256'(5));

    // Decode reads, with writer still requesting
    for (int a = 0; a < 16; a++) begin
      i_dec_k_mat_en = 1'b1;
      i_dec_k_mat_addr = 4'(a);
      i_wr_req = 1'b1;
      #1;
      if (a == 1) chk("dec_pulse_off", 256'(o_dec_start), 256'(0));
      if (a == 0) chk("dec_gnt", 256'({o_wr_gnt, o_ram_we}), 256'(0));
      chk("dec_ram_addr", 256'({o_ram_en, o_ram_addr}),
          256'({1'b1, 4'(a)}));
      tick();
      chk("dec_rdata", 256'(o_dec_k_mat), 256'(a));
    end
    i_dec_k_mat_en = 1'b0;
    i_dec_done = 1'b1;
    i_dec_k = key_a5;
    tick();
    i_dec_done = 1'b0;
    i_dec_k = '0;
    chk("hold_valid", 256'(o_k_valid), 256'(1));
    chk("hold_k", o_k, key_a5);

    // HOLD: writer and start both ignored
    i_start = 1'b1;
    i_sec_level = 3'd3;
    #1;
    chk("hold_gnt", 256'({o_wr_gnt, o_ram_we, o_ram_en}), 256'(0));
    tick(); tick(); tick();
    i_start = 1'b0;
    i_wr_req = 1'b0;
    chk("hold_stable", 256'({o_k_valid, o_busy}), 256'(3));
    chk("hold_k2", o_k, key_a5);
    i_k_ack = 1'b1;
    tick();
    i_k_ack = 1'b0;
    chk("ack_valid", 256'({o_k_valid, o_busy}), 256'(0));
    chk("ack_lvl", 256'(o_dec_sec_level), 256'(5));

    // Illegal level
    do_start(3'd2);
    i_wr_req = 1'b1;
    #1;
    chk("bad_err", 256'(o_err), 256'(1));
    chk("bad_busy_gnt", 256'({o_busy, o_wr_gnt}), 256'(0));
    tick();
    i_wr_req = 1'b0;
    chk("bad_err_pulse", 256'(o_err), 256'(0));

    // Watchdog timeout
    do_start(3'd3);
    fill(16, grants);
    chk("to_grants", 256'(grants), 256'(16));
    chk("to_start", 256'(o_dec_start), 256'(1));
    chk("to_lvl", 256'(o_dec_sec_level), 256'(3));
    cyc = 0;
    while (!o_err && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("to_cycles", 256'(cyc), 256'(64));
    chk("to_idle", 256'({o_busy, o_k_valid}), 256'(0));
    chk("to_k_kept", o_k, key_a5);
    tick();
    chk("to_err_pulse", 256'(o_err), 256'(0));

    // Reset mid-fill
    do_start(3'd1);
    fill(7, grants);
    chk("rf_grants", 256'(grants), 256'(7));
    #2;
    i_rst = 1'b1;
    #1;
    chk("rf_busy", 256'(o_busy), 256'(0));
    chk("rf_k", o_k, 256'(0));
    tick();
    i_rst = 1'b0;
    tick();
    do_start(3'd1);
    fill(15, grants);
    chk("rf_15", 256'({o_dec_start, o_busy}), 256'(1));
    fill(1, grants);
    chk("rf_16", 256'(o_dec_start), 256'(1));
    chk("rf_lvl", 256'(o_dec_sec_level), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
